// File: rtl/tenG_xgmii_pkg.sv
// tenG_xgmii_pkg: XGMII character constants and the RX frame-checker state type,
// shared by the 10G PCS/PMA test-path blocks.
package tenG_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE    = 8'h07;
    localparam logic [7:0] XGMII_START   = 8'hFB;
    localparam logic [7:0] XGMII_PRE     = 8'h55;
    localparam logic [7:0] XGMII_SFD     = 8'hD5;
    localparam logic [7:0] XGMII_TERM_FD = 8'hFD;
    localparam logic [7:0] XGMII_TERM_FE = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        SFD,
        DATA
    } state_e;

endpackage

// File: rtl/xgmii_term_locate.sv
// xgmii_term_locate: finds the terminate lane in one XGMII column.
// The search runs from lane 7 (first on the wire) down to lane 0; the first
// control lane carrying the terminate character wins. tail_idle_o reports
// whether every lane below the terminate is a control idle (07, rxc set).
module xgmii_term_locate
    import tenG_xgmii_pkg::*;
#(
    parameter logic [7:0] P_TERM_CHAR = XGMII_TERM_FE
) (
    input  logic [63:0] rxd_i,
    input  logic [7:0]  rxc_i,
    output logic        term_vld_o,
    output logic [2:0]  term_lane_o,
    output logic        tail_idle_o
);

    // Priority search for the terminate lane and qualification of the lanes after it
    always_comb begin
        term_vld_o  = 1'b0;
        term_lane_o = 3'd0;
        tail_idle_o = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (!term_vld_o && rxc_i[k] && (rxd_i[8*k +: 8] == P_TERM_CHAR)) begin
                term_vld_o  = 1'b1;
                term_lane_o = 3'(k);
            end else if (term_vld_o && !(rxc_i[k] && (rxd_i[8*k +: 8] == XGMII_IDLE))) begin
                tail_idle_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_frame_chk.sv
// xgmii_rx_frame_chk: XGMII RX frame checker for the 10G test path.
// Delineates frames by start / SFD / terminate, checks preamble, framing and
// payload length, and reports a one-cycle good/bad pulse with the payload
// length plus saturating good/bad frame counters.
// Build option: define RX_CHK_PATTERN_EN to compile in the incrementing-byte
// payload check (byte n of the payload must equal n mod 256).
module xgmii_rx_frame_chk
    import tenG_xgmii_pkg::*;
#(
    parameter int unsigned P_MAX_LEN   = 9600,
    parameter int unsigned P_MIN_LEN   = 1,
    parameter logic [7:0]  P_TERM_CHAR = XGMII_TERM_FE
) (
    input  logic        i_xgmii_clk,
    input  logic        i_xgmii_rst,
    input  logic [63:0] i_xgmii_rxd,
    input  logic [7:0]  i_xgmii_rxc,
    input  logic        i_cnt_clr,
    output logic        o_frame_good,
    output logic        o_frame_bad,
    output logic [15:0] o_frame_len,
    output logic [31:0] o_good_cnt,
    output logic [31:0] o_bad_cnt
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_e      state_q;
    logic        err_q;
    logic [15:0] len_q;
    logic        good_q;
    logic        bad_q;
    logic [15:0] olen_q;
    logic [31:0] good_cnt_q;
    logic [31:0] bad_cnt_q;

    logic        is_start;
    logic        pre_ok;
    logic        all_idle;
    logic        sfd_ok;
    logic        term_vld;
    logic [2:0]  term_lane;
    logic        tail_idle;
    logic [7:0]  above_mask;
    logic        above_ctrl;
    logic        data_term;

    logic [3:0]  add_len;
    logic        col_err;
    logic        pat_err;
    logic [16:0] len_sum;
    logic [15:0] len_d;
    logic        len_bad;
    logic        frame_err;
    logic        sfd_fail;
    logic        end_good_d;
    logic        end_bad_d;
    logic [15:0] end_len_d;

    assign is_start = (i_xgmii_rxc == 8'h80) && (i_xgmii_rxd[63:56] == XGMII_START);
    assign pre_ok   = (i_xgmii_rxd[55:0] == {7{XGMII_PRE}});
    assign all_idle = (i_xgmii_rxc == 8'hFF) && (i_xgmii_rxd == {8{XGMII_IDLE}});
    assign sfd_ok   = (i_xgmii_rxc == 8'h00) && (i_xgmii_rxd[63:56] == XGMII_SFD);

    xgmii_term_locate #(
        .P_TERM_CHAR (P_TERM_CHAR)
    ) u_term_locate (
        .rxd_i       (i_xgmii_rxd),
        .rxc_i       (i_xgmii_rxc),
        .term_vld_o  (term_vld),
        .term_lane_o (term_lane),
        .tail_idle_o (tail_idle)
    );

    // Lanes above the terminate lane are payload and must not carry control
    always_comb begin
        above_mask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            above_mask[k] = (3'(k) > term_lane);
        end
    end

    assign above_ctrl = |(i_xgmii_rxc & above_mask);
    // A restart or an all-idle column takes precedence over a terminate
    assign data_term  = term_vld && !is_start && !all_idle;

    // Payload bytes contributed by this column and any framing error it carries
    always_comb begin
        add_len = 4'd0;
        col_err = 1'b0;
        case (state_q)
            SFD: add_len = 4'd7;
            DATA: begin
                if (!(is_start || all_idle)) begin
                    if (term_vld) begin
                        add_len = 4'd7 - {1'b0, term_lane};
                        col_err = above_ctrl || !tail_idle;
                    end else begin
                        add_len = 4'd8;
                        col_err = (i_xgmii_rxc != 8'h00);
                    end
                end
            end
            default: add_len = 4'd0;
        endcase
    end

`ifdef RX_CHK_PATTERN_EN
    logic [7:0] exp_q;
    logic [7:0] pay_mask;
    logic [7:0] first_lane;

    // Payload lanes of this column and the wire position offset of the top lane
    always_comb begin
        pay_mask   = 8'h00;
        first_lane = 8'd7;
        case (state_q)
            SFD: begin
                pay_mask   = 8'h7F;
                first_lane = 8'd6;
            end
            DATA: begin
                if (!(is_start || all_idle)) begin
                    pay_mask = term_vld ? above_mask : ~i_xgmii_rxc;
                end
            end
            default: pay_mask = 8'h00;
        endcase
    end

    // Compare every payload lane against the incrementing expected byte
    always_comb begin
        pat_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (pay_mask[k] && (i_xgmii_rxd[8*k +: 8] != (exp_q + first_lane - 8'(k)))) begin
                pat_err = 1'b1;
            end
        end
    end

    // Expected-byte counter: restarts with each frame, advances per payload byte
    always_ff @(posedge i_xgmii_clk or posedge i_xgmii_rst) begin
        if (i_xgmii_rst) begin
            exp_q <= 8'h00;
        end else if ((state_q == IDLE) || is_start) begin
            exp_q <= 8'h00;
        end else begin
            exp_q <= exp_q + {4'd0, add_len};
        end
    end
`else
    assign pat_err = 1'b0;
`endif

    assign len_sum   = {1'b0, len_q} + {13'd0, add_len};
    assign len_d     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign len_bad   = ({16'd0, len_d} > P_MAX_LEN) || ({16'd0, len_d} < P_MIN_LEN);
    assign frame_err = err_q || col_err || pat_err || len_bad;

    assign sfd_fail   = (state_q == SFD) && !sfd_ok;
    assign end_good_d = (state_q == DATA) && data_term && !frame_err;
    assign end_bad_d  = sfd_fail ||
                        ((state_q == DATA) && (is_start || all_idle || (data_term && frame_err)));
    assign end_len_d  = sfd_fail ? 16'd0 : len_d;

    // Frame state machine with registered end pulse and length
    always_ff @(posedge i_xgmii_clk or posedge i_xgmii_rst) begin
        if (i_xgmii_rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            len_q   <= 16'd0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            olen_q  <= 16'd0;
        end else begin
            good_q <= end_good_d;
            bad_q  <= end_bad_d;
            if (end_good_d || end_bad_d) begin
                olen_q <= end_len_d;
            end
            case (state_q)
                IDLE: begin
                    if (is_start) begin
                        state_q <= SFD;
                        err_q   <= !pre_ok;
                        len_q   <= 16'd0;
                    end
                end
                SFD: begin
                    if (sfd_ok) begin
                        state_q <= DATA;
                        err_q   <= err_q || pat_err;
                        len_q   <= len_d;
                    end else begin
                        state_q <= IDLE;
                        err_q   <= 1'b0;
                        len_q   <= 16'd0;
                    end
                end
                DATA: begin
                    if (is_start) begin
                        state_q <= SFD;
                        err_q   <= !pre_ok;
                        len_q   <= 16'd0;
                    end else if (all_idle || term_vld) begin
                        state_q <= IDLE;
                        err_q   <= 1'b0;
                        len_q   <= 16'd0;
                    end else begin
                        err_q <= err_q || col_err || pat_err;
                        len_q <= len_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                    len_q   <= 16'd0;
                end
            endcase
        end
    end

    // Saturating good/bad counters; a clear coinciding with an end loads 1
    always_ff @(posedge i_xgmii_clk or posedge i_xgmii_rst) begin
        if (i_xgmii_rst) begin
            good_cnt_q <= 32'd0;
            bad_cnt_q  <= 32'd0;
        end else if (i_cnt_clr) begin
            good_cnt_q <= end_good_d ? 32'd1 : 32'd0;
            bad_cnt_q  <= end_bad_d  ? 32'd1 : 32'd0;
        end else begin
            if (end_good_d && (good_cnt_q != CNT_MAX)) begin
                good_cnt_q <= good_cnt_q + 32'd1;
            end
            if (end_bad_d && (bad_cnt_q != CNT_MAX)) begin
                bad_cnt_q <= bad_cnt_q + 32'd1;
            end
        end
    end

    assign o_frame_good = good_q;
    assign o_frame_bad  = bad_q;
    assign o_frame_len  = olen_q;
    assign o_good_cnt   = good_cnt_q;
    assign o_bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_frame_chk.sv
// tb_xgmii_rx_frame_chk: directed bench for the XGMII RX frame checker.
module tb_xgmii_rx_frame_chk;

    localparam logic [63:0] IDLE_COL  = 64'h0707070707070707;
    localparam logic [63:0] START_COL = 64'hFB55555555555555;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        cnt_clr;
    logic        frame_good;
    logic        frame_bad;
    logic [15:0] frame_len;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    int checks   = 0;
    int failures = 0;
    int n_good   = 0;
    int n_bad    = 0;
    logic [15:0] good_len = 16'd0;
    logic [15:0] bad_len  = 16'd0;
    logic [31:0] exp_g    = 32'd0;
    logic [31:0] exp_b    = 32'd0;

    always #5 clk = ~clk;

    xgmii_rx_frame_chk dut (
        .i_xgmii_clk  (clk),
        .i_xgmii_rst  (rst),
        .i_xgmii_rxd  (rxd),
        .i_xgmii_rxc  (rxc),
        .i_cnt_clr    (cnt_clr),
        .o_frame_good (frame_good),
        .o_frame_bad  (frame_bad),
        .o_frame_len  (frame_len),
        .o_good_cnt   (good_cnt),
        .o_bad_cnt    (bad_cnt)
    );

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (frame_good) begin
            n_good   = n_good + 1;
            good_len = frame_len;
        end
        if (frame_bad) begin
            n_bad   = n_bad + 1;
            bad_len = frame_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_col(input logic [63:0] d, input logic [7:0] c, input logic clr);
        @(negedge clk);
        rxd     = d;
        rxc     = c;
        cnt_clr = clr;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) send_col(IDLE_COL, 8'hFF, 1'b0);
    endtask

    task automatic clear_mon();
        n_good = 0;
        n_bad  = 0;
    endtask

    // Generator frame: 70 incrementing payload bytes. bad_idx bumps one byte,
    // idle_col replaces that data column with all-idle, ncols truncates.
    task automatic send_frame(input logic [63:0] start_c, input logic [7:0] sfd_b,
                              input int bad_idx, input int idle_col,
                              input int ncols, input logic clr_on_term);
        logic [7:0]  b [0:69];
        logic [63:0] d;
        for (int i = 0; i < 70; i++) b[i] = 8'(i);
        if (bad_idx >= 0) b[bad_idx] = b[bad_idx] + 8'd1;
        if (ncols > 0) send_col(start_c, 8'h80, 1'b0);
        if (ncols > 1) begin
            d[63:56] = sfd_b;
            for (int k = 0; k < 7; k++) d[8*(6-k) +: 8] = b[k];
            send_col(d, 8'h00, 1'b0);
        end
        for (int j = 0; j < 7; j++) begin
            if (ncols > 2 + j) begin
                if (j == idle_col) begin
                    send_col(IDLE_COL, 8'hFF, 1'b0);
                end else begin
                    for (int k = 0; k < 8; k++) d[8*(7-k) +: 8] = b[7 + 8*j + k];
                    send_col(d, 8'h00, 1'b0);
                end
            end
        end
        if (ncols > 9) begin
            for (int k = 0; k < 7; k++) d[8*(7-k) +: 8] = b[63 + k];
            d[7:0] = 8'hFE;
            send_col(d, 8'h01, clr_on_term);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rxd     = IDLE_COL;
        rxc     = 8'hFF;
        cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_good", 32'(frame_good), 32'd0);
        check("rst_bad", 32'(frame_bad), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        check("rst_gcnt", good_cnt, 32'd0);
        check("rst_bcnt", bad_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idles(2);

        // Generator frame: pulse one cycle after the terminate is sampled
        clear_mon();
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
        send_col(IDLE_COL, 8'hFF, 1'b0);
        #1;
        check("gen_good", 32'(frame_good), 32'd1);
        check("gen_bad", 32'(frame_bad), 32'd0);
        check("gen_len", 32'(frame_len), 32'd70);
        exp_g = exp_g + 1;
        check("gen_gcnt", good_cnt, exp_g);
        send_col(IDLE_COL, 8'hFF, 1'b0);
        #1;
        check("gen_pulse_width", 32'(frame_good), 32'd0);
        idles(2);
        check("gen_npulse", 32'(n_good), 32'd1);

        // Corrupted payload byte 0x20 -> 0x21
        clear_mon();
        send_frame(START_COL, 8'hD5, 32, -1, 10, 1'b0);
        idles(3);
`ifdef RX_CHK_PATTERN_EN
        exp_b = exp_b + 1;
        check("pat_nbad", 32'(n_bad), 32'd1);
        check("pat_len", 32'(bad_len), 32'd70);
`else
        exp_g = exp_g + 1;
        check("pat_ngood", 32'(n_good), 32'd1);
        check("pat_len", 32'(good_len), 32'd70);
`endif
        check("pat_gcnt", good_cnt, exp_g);
        check("pat_bcnt", bad_cnt, exp_b);

        // Bad SFD, then a good frame
        clear_mon();
        send_frame(START_COL, 8'h55, -1, -1, 10, 1'b0);
        idles(3);
        exp_b = exp_b + 1;
        check("sfd_nbad", 32'(n_bad), 32'd1);
        check("sfd_ngood", 32'(n_good), 32'd0);
        check("sfd_len", 32'(bad_len), 32'd0);
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
        idles(3);
        exp_g = exp_g + 1;
        check("sfd_next_ngood", 32'(n_good), 32'd1);
        check("sfd_gcnt", good_cnt, exp_g);
        check("sfd_bcnt", bad_cnt, exp_b);

        // All-idle column replacing the fifth data column
        clear_mon();
        send_frame(START_COL, 8'hD5, -1, 4, 10, 1'b0);
        idles(3);
        exp_b = exp_b + 1;
        check("idle_nbad", 32'(n_bad), 32'd1);
        check("idle_ngood", 32'(n_good), 32'd0);
        check("idle_len", 32'(bad_len), 32'd39);

        // Bad preamble byte in the start column
        clear_mon();
        send_frame(64'hFB55555555555554, 8'hD5, -1, -1, 10, 1'b0);
        idles(3);
        exp_b = exp_b + 1;
        check("pre_nbad", 32'(n_bad), 32'd1);
        check("pre_len", 32'(bad_len), 32'd70);

        // Shortest frame: terminate in lane 7 right after the SFD column
        clear_mon();
        send_col(START_COL, 8'h80, 1'b0);
        send_col(64'hD500010203040506, 8'h00, 1'b0);
        send_col(64'hFE07070707070707, 8'hFF, 1'b0);
        idles(3);
        exp_g = exp_g + 1;
        check("short_ngood", 32'(n_good), 32'd1);
        check("short_len", 32'(good_len), 32'd7);

        // Terminate followed by a non-idle lane
        clear_mon();
        send_col(START_COL, 8'h80, 1'b0);
        send_col(64'hD500010203040506, 8'h00, 1'b0);
        send_col(64'hFE07070707070700, 8'hFE, 1'b0);
        idles(3);
        exp_b = exp_b + 1;
        check("tail_nbad", 32'(n_bad), 32'd1);
        check("tail_len", 32'(bad_len), 32'd7);
        check("tail_gcnt", good_cnt, exp_g);
        check("tail_bcnt", bad_cnt, exp_b);

        // Back-to-back frames: start right after terminate
        clear_mon();
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
        idles(3);
        exp_g = exp_g + 2;
        check("b2b_ngood", 32'(n_good), 32'd2);
        check("b2b_gcnt", good_cnt, exp_g);

        // Reset during the fourth column, then a full frame
        clear_mon();
        send_frame(START_COL, 8'hD5, -1, -1, 3, 1'b0);
        @(negedge clk);
        rxd = 64'h0F10111213141516;
        rxc = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = IDLE_COL;
        rxc = 8'hFF;
        idles(3);
        exp_g = 32'd0;
        exp_b = 32'd0;
        check("rstmid_npulse", 32'(n_good + n_bad), 32'd0);
        check("rstmid_gcnt0", good_cnt, exp_g);
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
        idles(3);
        exp_g = 32'd1;
        check("rstmid_ngood", 32'(n_good), 32'd1);
        check("rstmid_nbad", 32'(n_bad), 32'd0);
        check("rstmid_gcnt", good_cnt, exp_g);
        check("rstmid_bcnt", bad_cnt, exp_b);

        // Build good_cnt up to 5, then clear on the pulse edge
        for (int i = 0; i < 4; i++) begin
            send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b0);
            idles(1);
        end
        idles(2);
        check("clr_pre_gcnt", good_cnt, 32'd5);
        send_frame(START_COL, 8'hD5, -1, -1, 10, 1'b1);
        send_col(IDLE_COL, 8'hFF, 1'b0);
        #1;
        check("clr_pulse", 32'(frame_good), 32'd1);
        check("clr_gcnt", good_cnt, 32'd1);
        check("clr_bcnt", bad_cnt, 32'd0);

        // Plain clear with no end pulse
        send_frame(START_COL, 8'hD5, -1, 4, 10, 1'b0);
        idles(3);
        check("clr2_pre_bcnt", bad_cnt, 32'd1);
        send_col(IDLE_COL, 8'hFF, 1'b1);
        send_col(IDLE_COL, 8'hFF, 1'b0);
        #1;
        check("clr2_gcnt", good_cnt, 32'd0);
        check("clr2_bcnt", bad_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_frame_chk.md
# xgmii_rx_frame_chk

Receive-side XGMII frame checker for the 10G PCS/PMA test path. It consumes the 64-bit XGMII RX column stream from the PCS and delineates frames by start, SFD and terminate. It checks preamble, framing and payload length, and optionally checks the incrementing-byte test payload that our TX test generator sends. It reports a per-frame good/bad pulse with the payload length and keeps running good/bad frame counters.

## Interface
Parameters:
- P_MAX_LEN, 9600: maximum legal payload bytes between the SFD and the terminate.
- P_MIN_LEN, 1: minimum legal payload bytes.
- P_TERM_CHAR, 8'hFE: terminate control character. Our TX test path uses FE. 8'hFD is the IEEE value.

Ports:
- i_xgmii_clk  in  1  XGMII clock, 156.25 MHz. This is the only clock.
- i_xgmii_rst  in  1  Reset, asynchronous, active-high.
- i_xgmii_rxd  in  64  RX data. Lane 7 is bits [63:56] and is the first byte on the wire. Lane 0 is bits [7:0].
- i_xgmii_rxc  in  8  RX control flags. Bit k belongs to lane k.
- i_cnt_clr  in  1  Synchronous clear of the good/bad frame counters.
- o_frame_good  out  1  One-cycle pulse: the frame ended and passed all checks.
- o_frame_bad  out  1  One-cycle pulse: the frame ended with at least one error.
- o_frame_len  out  16  Payload byte count. Valid while either pulse is high. Saturates at 16'hFFFF.
- o_good_cnt  out  32  Good-frame counter. Saturates at 32'hFFFF_FFFF.
- o_bad_cnt  out  32  Bad-frame counter. Saturates at 32'hFFFF_FFFF.

## Operation
- Start column: rxc = 8'h80, lane 7 = FB, lanes 6..0 = 55. Only lane-7 starts are recognised. Any other column seen in IDLE is ignored.
- State machine IDLE -> SFD -> DATA -> IDLE:
  - IDLE: a valid start column moves to SFD. A start column with rxc = 80 and FB in lane 7 but a lane 6..0 byte other than 55 also moves to SFD, with the error flag set.
  - SFD: the column must have rxc = 00 and lane 7 = D5. Lanes 6..0 are payload bytes 0..6 and are counted and checked. On a bad SFD: issue a bad pulse with len = 0 and return to IDLE.
  - DATA, no control bits set: add 8 to the length and check all 8 bytes.
  - DATA, terminate column: the lane holding P_TERM_CHAR with its rxc bit set ends the frame. Lanes above it are payload. Lanes below it must be 07 with rxc set; anything else sets the error flag. Issue the end pulse and go to IDLE.
- DATA error cases:
  - Any other control byte: set the error flag and continue.
  - An all-idle column (rxc = FF, all bytes 07) with no terminate: bad end, go to IDLE.
  - A new start column: bad end for the current frame, then treat the column as a new start and go to SFD.
- Length errors: a final length > P_MAX_LEN or < P_MIN_LEN makes the frame bad.
- Pattern check: an expected-byte counter loads 00 at the first payload byte, advances 1 per payload byte, and wraps FF -> 00. The byte in lane k of a full data column must equal exp + (7 - k).
- Counters: each end pulse increments the matching counter. i_cnt_clr zeroes both counters. If i_cnt_clr coincides with an end pulse, the matching counter loads 1.

## Timing
- Reset values: state IDLE; o_frame_good = 0, o_frame_bad = 0, o_frame_len = 0, o_good_cnt = 0, o_bad_cnt = 0. The error flag and length accumulator are cleared.
- Pulse latency: the pulse is registered and asserts in the cycle after the edge that samples the terminate, idle or restarting column. It lasts exactly one cycle.
- Counter latency: counters update on the same edge as the pulse is raised.
- Back-to-back frames: a start column in the cycle right after a terminate column is accepted. The checker sustains one frame end per two columns.
- Reset mid-frame: the in-progress frame is discarded. No pulse is issued and no counter changes.

## Configuration
- RX_CHK_PATTERN_EN defined: the incrementing-payload check is compiled in, and a mismatch marks the frame bad.
- RX_CHK_PATTERN_EN undefined: the expected-byte counter and comparators are removed. Only framing, preamble, SFD and length are checked.

## Structure
- Shared package tenG_xgmii_pkg holds the character constants:
  - XGMII_IDLE 8'h07
  - XGMII_START 8'hFB
  - XGMII_PRE 8'h55
  - XGMII_SFD 8'hD5
  - XGMII_TERM_FD 8'hFD
  - XGMII_TERM_FE 8'hFE
  - the state enum {IDLE, SFD, DATA}
- Sub-module xgmii_term_locate: combinational priority encoder returning the terminate-lane index and a valid bit from rxd/rxc, plus a flag that lanes below it are proper idles.

## Test plan
- Generator frame, RX_CHK_PATTERN_EN defined. Input columns, data/rxc:
  - FB555555_55555555 / 80
  - D5000102_03040506 / 00
  - seven data columns running 0708090a_0b0c0d0e ... 3738393a_3b3c3d3e, rxc 00
  - 3f404142_434445FE / 01
  - then idle

  Required: o_frame_good for one cycle, o_frame_len = 70, good_cnt = 1.
- The same frame with byte 0x20 changed to 0x21. With RX_CHK_PATTERN_EN: o_frame_bad, len = 70, bad_cnt = 1. Without the macro: o_frame_good.
- The SFD column D5 replaced by 55: o_frame_bad with len = 0, then IDLE. A following good frame is counted good.
- The generator frame with an all-idle column (07070707_07070707 / FF) replacing its fifth data column: o_frame_bad, len = 39.
- Reset asserted during the fourth column, then a full frame: exactly one pulse (good), good_cnt = 1, bad_cnt = 0.
- i_cnt_clr asserted on the pulse edge of a good frame, with good_cnt = 5 beforehand: good_cnt reads 1.
